// File: rtl/matrix_loader_if.sv
// Byte-stream input and matrix RAM write-port bundle for matrix_loader.
interface matrix_loader_if #(
  parameter int unsigned N = 128
);
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         w_en;
  logic [7:0]   w_addr;
  logic [N-1:0] w_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, w_en, w_addr, w_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, w_en, w_addr, w_data
  );
endinterface

// File: rtl/matrix_loader.sv
// Packs an MSB-first byte stream into N-bit rows and writes rows 0..M-1 to the matrix RAM.
// Optional trailing XOR checksum byte: define MATRIX_LOADER_CKSUM_EN.
module matrix_loader #(
  parameter int unsigned M = 256,
  parameter int unsigned N = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  matrix_loader_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             cksum_err
);

  localparam int unsigned   BYTES     = N / 8;
  localparam int unsigned   BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
  localparam logic [7:0]    LAST_ROW  = 8'(M - 1);

`ifdef MATRIX_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, FILL, WRITE, CHECK, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, FILL, WRITE, FIN} state_t;
`endif

  state_t         state_q, state_d;
  logic [7:0]     row_q, row_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           w_en_q;
  logic           in_ready_w;
  logic           accept;

`ifdef MATRIX_LOADER_CKSUM_EN
  assign in_ready_w = (state_q == FILL) || (state_q == CHECK);
`else
  assign in_ready_w = (state_q == FILL);
`endif
  assign accept = bus.in_valid && in_ready_w;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL:  if (accept && (cnt_q == LAST_BYTE)) state_d = WRITE;
      WRITE: begin
        if (row_q == LAST_ROW) begin
`ifdef MATRIX_LOADER_CKSUM_EN
          state_d = CHECK;
`else
          state_d = FIN;
`endif
        end else begin
          state_d = FILL;
        end
      end
`ifdef MATRIX_LOADER_CKSUM_EN
      CHECK: if (accept) state_d = FIN;
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d   = row_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if ((state_q == IDLE) && start) begin
      row_d = '0;
      cnt_d = '0;
    end
    if ((state_q == FILL) && accept) begin
      // Shift-in keeps the first byte of the row in the top lane.
      shift_d = (shift_q << 8) | N'(bus.in_data);
      cnt_d   = (cnt_q == LAST_BYTE) ? '0 : cnt_q + BW'(1);
    end
    if ((state_q == WRITE) && (row_q != LAST_ROW)) begin
      row_d = row_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      w_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      w_en_q  <= (state_d == WRITE);
    end
  end

`ifdef MATRIX_LOADER_CKSUM_EN
  logic [7:0] ck_q, ck_d;
  logic       err_q, err_d;

  always_comb begin
    ck_d  = ck_q;
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      ck_d  = '0;
      err_d = 1'b0;
    end
    if ((state_q == FILL) && accept) ck_d = ck_q ^ bus.in_data;
    if ((state_q == CHECK) && accept) err_d = (bus.in_data != ck_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ck_q  <= ck_d;
      err_q <= err_d;
    end
  end

  assign cksum_err = err_q;
`else
  assign cksum_err = 1'b0;
`endif

  // Row address and data come straight from the registers held during WRITE.
  assign bus.in_ready = in_ready_w;
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = row_q;
  assign bus.w_data   = shift_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: a small M=4/N=32 instance and a default-size instance.
module tb_matrix_loader;
  localparam int unsigned SM = 4;
  localparam int unsigned SN = 32;
  localparam int unsigned LM = 256;
  localparam int unsigned LN = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0, start_l = 1'b0;
  logic busy_s, done_s, err_s, busy_l, done_l, err_l;

  always #5 clk = ~clk;

  matrix_loader_if #(.N(SN)) bus_s ();
  matrix_loader_if #(.N(LN)) bus_l ();

  matrix_loader #(.M(SM), .N(SN)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bus_s.master),
    .busy(busy_s), .done(done_s), .cksum_err(err_s)
  );

  matrix_loader #(.M(LM), .N(LN)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .bus(bus_l.master),
    .busy(busy_l), .done(done_l), .cksum_err(err_l)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [39:0]  wq_s[$];
  logic [135:0] wq_l[$];
  logic         dq_s[$];
  logic         dq_l[$];
  int           done_cnt_s = 0, done_cnt_l = 0, wen_cyc_s = 0;
  logic [7:0]   last_addr_s = '0;
  bit           prev_done_s = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Small-instance monitor: write scoreboard, done/cksum, timing and in_ready shape.
  always @(negedge clk) begin
    logic [39:0] e;
    logic        de;
    if (bus_s.w_en) begin
      if (wq_s.size() == 0) chk("s_unexpected_write", {bus_s.w_addr, bus_s.w_data}, '1);
      else begin
        e = wq_s.pop_front();
        chk("s_write", {bus_s.w_addr, bus_s.w_data}, e);
      end
      wen_cyc_s   = cyc;
      last_addr_s = bus_s.w_addr;
    end
    if (done_s) begin
      done_cnt_s++;
      if (dq_s.size() == 0) chk("s_unexpected_done", 0, 1);
      else begin
        de = dq_s.pop_front();
        chk("s_cksum_err_at_done", err_s, de);
      end
      chk("s_last_addr_at_done", last_addr_s, SM - 1);
`ifndef MATRIX_LOADER_CKSUM_EN
      chk("s_done_after_last_write", cyc - wen_cyc_s, 1);
`endif
    end
    if (prev_done_s) chk("s_busy_after_done", busy_s, 0);
    prev_done_s = done_s;
    chk("s_in_ready_shape", bus_s.in_ready, busy_s && !bus_s.w_en && !done_s);
  end

  always @(negedge clk) begin
    logic [135:0] e;
    logic         de;
    if (bus_l.w_en) begin
      if (wq_l.size() == 0) chk("l_unexpected_write", {bus_l.w_addr, bus_l.w_data}, '1);
      else begin
        e = wq_l.pop_front();
        chk("l_write", {bus_l.w_addr, bus_l.w_data}, e);
      end
    end
    if (done_l) begin
      done_cnt_l++;
      if (dq_l.size() == 0) chk("l_unexpected_done", 0, 1);
      else begin
        de = dq_l.pop_front();
        chk("l_cksum_err_at_done", err_l, de);
      end
    end
  end

  // All tasks enter and leave at posedge+1.
  task automatic send(input bit sel, input logic [7:0] b, input bit gap);
    bit r;
    int g;
    if (gap) begin
      @(posedge clk);
      #1;
    end
    if (sel) begin bus_l.in_valid = 1'b1; bus_l.in_data = b; end
    else     begin bus_s.in_valid = 1'b1; bus_s.in_data = b; end
    r = 1'b0;
    g = 0;
    while (!r && g < 100) begin
      @(negedge clk);
      r = sel ? bus_l.in_ready : bus_s.in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!r) chk("send_timeout", 0, 1);
    if (sel) bus_l.in_valid = 1'b0;
    else     bus_s.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel, input bit check);
    if (sel) start_l = 1'b1; else start_s = 1'b1;
    @(posedge clk);
    #1;
    start_l = 1'b0;
    start_s = 1'b0;
    if (check) begin
      chk("busy_after_start",     sel ? busy_l : busy_s, 1);
      chk("in_ready_after_start", sel ? bus_l.in_ready : bus_s.in_ready, 1);
    end
  endtask

  task automatic push_rows_s(input int n);
    logic [31:0] d;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 4; k++) d[31-8*k -: 8] = 8'(4 * r + k);
      wq_s.push_back({8'(r), d});
    end
  endtask

  task automatic wait_done(input bit sel, input int target, input int budget);
    int g;
    g = 0;
    while (((sel ? done_cnt_l : done_cnt_s) < target) && g < budget) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", sel ? done_cnt_l : done_cnt_s, target);
    chk("writes_pending", sel ? wq_l.size() : wq_s.size(), 0);
  endtask

  task automatic check_idle_s(input string tag);
    chk({tag, "_in_ready"}, bus_s.in_ready, 0);
    chk({tag, "_w_en"},     bus_s.w_en, 0);
    chk({tag, "_w_addr"},   bus_s.w_addr, 0);
    chk({tag, "_w_data"},   bus_s.w_data, 0);
    chk({tag, "_busy"},     busy_s, 0);
    chk({tag, "_done"},     done_s, 0);
    chk({tag, "_cksum"},    err_s, 0);
  endtask

  task automatic load_s(input bit gap, input logic [7:0] trailer, input logic exp_err);
    push_rows_s(SM);
    dq_s.push_back(exp_err);
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i), gap);
`ifdef MATRIX_LOADER_CKSUM_EN
    send(1'b0, trailer, gap);
`endif
  endtask

  initial begin
    logic [127:0] d;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0;
    bus_l.in_valid = 1'b0; bus_l.in_data = '0;
    #1;
    check_idle_s("reset");
    chk("reset_l_busy", busy_l, 0);
    chk("reset_l_w_en", bus_l.w_en, 0);
    chk("reset_l_w_data", bus_l.w_data, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream, then with in_valid idling every other cycle.
    load_s(1'b0, 8'h00, 1'b0);
    wait_done(1'b0, 1, 100);
    load_s(1'b1, 8'h00, 1'b0);
    wait_done(1'b0, 2, 100);

    // start mid-load must be ignored.
    push_rows_s(SM);
    dq_s.push_back(1'b0);
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 1'b0);
    pulse_start(1'b0, 1'b0);
    for (int i = 6; i < 16; i++) send(1'b0, 8'(i), 1'b0);
`ifdef MATRIX_LOADER_CKSUM_EN
    send(1'b0, 8'h00, 1'b0);
`endif
    wait_done(1'b0, 3, 100);

    // Reset after six bytes: only row 0 reaches the RAM.
    push_rows_s(1);
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_s("midreset");
    chk("midreset_rows_written", wq_s.size(), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_s(1'b0, 8'h00, 1'b0);
    wait_done(1'b0, 4, 100);

`ifdef MATRIX_LOADER_CKSUM_EN
    load_s(1'b0, 8'h5A, 1'b1);
    wait_done(1'b0, 5, 100);
    chk("cksum_err_holds", err_s, 1);
`endif

    // Default geometry: 4096 bytes, byte i = i mod 256.
    for (int r = 0; r < 256; r++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(16 * r + k);
      wq_l.push_back({8'(r), d});
    end
    dq_l.push_back(1'b0);
    pulse_start(1'b1, 1'b1);
    for (int i = 0; i < 4096; i++) send(1'b1, 8'(i), 1'b0);
`ifdef MATRIX_LOADER_CKSUM_EN
    send(1'b1, 8'h00, 1'b0);
`endif
    wait_done(1'b1, 1, 100);
    chk("l_busy_end", busy_l, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
